// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads the combinational imem and
// queues {pc, instr} pairs toward decode; redirects flush the queue.
module if_fetch_ctrl #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          LAST_IDX = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [5:0]                 imem_a,
    input  logic [31:0]                imem_rd,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr_out,
    output logic [31:0]                pc_out,
    output logic [31:0]                pc_plus4,
    output logic                       fetch_done,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    // Decode handshake: a head entry transfers on any rising edge where
    // instr_valid && instr_ready; the head holds stable while instr_ready is low.

    logic [31:0]   pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [OW-1:0] count;
    logic          pop;
    logic          full;
    logic          fetch_go;
    logic          redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign imem_a      = pc[7:2];
    assign fetch_done  = (pc[31:2] > 30'(LAST_IDX));
    assign instr_valid = (count != '0);
    assign occupancy   = count;
    assign pop         = instr_valid && instr_ready;
    assign full        = (count == OW'(DEPTH));
    assign fetch_go    = !redirect_valid && !fetch_done && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            // A pop in this cycle still completes from decode's view; the entry is simply discarded.
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch_go) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({fetch_go, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only visible through instr_valid.
    always_ff @(posedge clk) begin
        if (fetch_go) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imem_rd;
        end
    end

    assign instr_out = instr_valid ? q_instr[rd_ptr] : 32'd0;
    assign pc_out    = instr_valid ? q_pc[rd_ptr]    : 32'd0;
    assign pc_plus4  = pc_out + 32'd4;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a scoreboard queue holds the PCs decode
// must see, in order; every completed handshake is popped and compared.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic [1:0]  occupancy;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [5:0] a);
        return 32'h1000_0000 + {26'd0, a} * 32'h0001_0101;
    endfunction

    assign imem_rd = imem_f(imem_a);

    if_fetch_ctrl #(.DEPTH(2), .RESET_PC(32'h0), .LAST_IDX(20)) dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .fetch_done(fetch_done), .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle sample; any completed handshake is checked against the scoreboard.
    task automatic sample();
        logic [31:0] e;
        @(negedge clk);
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_instr", pc_out, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pc_out", pc_out, e);
                chk("instr_out", instr_out, imem_f(e[7:2]));
                chk("pc_plus4", pc_plus4, e + 32'd4);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    task automatic drain(output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 200) begin
            tick();
            cycles++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Leaves the bench at the negedge where occupancy reached target.
    task automatic wait_occ(input logic [1:0] target);
        int k = 0;
        sample();
        while (occupancy != target && k < 50) begin
            adv();
            sample();
            k++;
        end
        chk("wait_occ_timeout", {31'd0, k >= 50}, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_imem_a"}, imem_a, 0);
        chk({tag, "_occ"}, occupancy, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr_out, 0);
        chk({tag, "_pc_out"}, pc_out, 0);
        chk({tag, "_pc_plus4"}, pc_plus4, 4);
        chk({tag, "_done"}, fetch_done, 0);
    endtask

    task automatic push_range(input int from_pc, input int to_pc);
        for (int p = from_pc; p <= to_pc; p += 4) exp_q.push_back(32'(p));
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        // Full program stream with decode always ready: no bubbles.
        instr_ready = 1'b1;
        push_range(0, 80);
        reset = 1'b0;
        drain(n);
        chk("stream_cycles", n, 22);
        sample();
        chk("end_valid", instr_valid, 0);
        chk("end_done", fetch_done, 1);
        chk("end_imem_a", imem_a, 21);
        adv();

        // Stall: queue fills, pc freezes, head holds.
        reset = 1'b1;
        instr_ready = 1'b0;
        adv();
        reset = 1'b0;
        wait_occ(1);
        adv();
        repeat (5) tick();
        sample();
        chk("stall_occ", occupancy, 2);
        chk("stall_imem_a", imem_a, 2);
        chk("stall_instr", instr_out, imem_f(6'd0));
        chk("stall_pc_out", pc_out, 0);
        adv();
        push_range(0, 8);
        instr_ready = 1'b1;
        repeat (3) tick();
        chk("release_left", exp_q.size(), 0);

        // Redirect while full: flush, then target two cycles later.
        instr_ready = 1'b0;
        wait_occ(2);
        adv();
        redirect_valid = 1'b1;
        redirect_pc = 32'd68;
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        push_range(68, 80);
        sample();
        chk("redir_occ", occupancy, 0);
        chk("redir_valid", instr_valid, 0);
        adv();
        drain(n);
        chk("redir_cycles", n, 4);
        sample();
        chk("redir_done", fetch_done, 1);
        adv();

        // Misaligned redirect out of the halted state.
        redirect_valid = 1'b1;
        redirect_pc = 32'h53;
        exp_q.push_back(32'h50);
        tick();
        redirect_valid = 1'b0;
        sample();
        chk("mis_done_clr", fetch_done, 0);
        chk("mis_imem_a", imem_a, 20);
        adv();
        drain(n);
        chk("mis_cycles", n, 1);
        sample();
        chk("mis_done_set", fetch_done, 1);
        chk("mis_valid", instr_valid, 0);
        adv();

        // Redirect beyond the program: halted, queue stays empty.
        redirect_valid = 1'b1;
        redirect_pc = 32'd200;
        tick();
        redirect_valid = 1'b0;
        sample();
        chk("far_done", fetch_done, 1);
        chk("far_imem_a", imem_a, 50);
        adv();
        repeat (3) tick();
        sample();
        chk("far_occ", occupancy, 0);
        chk("far_valid", instr_valid, 0);
        adv();

        // Asynchronous reset mid-cycle with a full queue and pending redirect.
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        wait_occ(2);
        adv();
        redirect_valid = 1'b1;
        redirect_pc = 32'd68;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        adv();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        push_range(0, 80);
        reset = 1'b0;
        drain(n);
        chk("post_rst_cycles", n, 22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
